// File: rtl/wb_sram_responder.sv
// Wishbone slave that terminates single outstanding host accesses onto one port of a
// single-port SRAM macro; out-of-range addresses are answered with a bus error.
module wb_sram_responder #(
  parameter int unsigned ADDRESS_WIDTH = 9,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [3:0]               wb_sel_i,
  input  logic [31:0]              wb_data_i,
  input  logic [27:0]              wb_adr_i,
  output logic                     wb_ack_o,
  output logic                     wb_stall_o,
  output logic                     wb_error_o,
  output logic [31:0]              wb_data_o,
  output logic                     sram_csb0,
  output logic                     sram_web0,
  output logic [3:0]               sram_wmask0,
  output logic [ADDRESS_WIDTH-1:0] sram_addr0,
  output logic [31:0]              sram_din0,
  input  logic [31:0]              sram_dout0
);

  typedef enum logic [2:0] {StIdle, StWrite, StReadWait, StRespond, StError} state_e;

  state_e                   r_state;
  logic [1:0]               r_cnt;
  logic                     r_ack;
  logic                     r_err;
  logic                     r_stall;
  logic                     r_csb;
  logic                     r_web;
  logic [3:0]               r_wmask;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [31:0]              r_din;
  logic [31:0]              r_data;

  logic                     w_req;
  logic                     w_oor;
  logic [ADDRESS_WIDTH-1:0] w_word;

  assign w_req  = wb_cyc_i & wb_stb_i;
  // Any address bit above the word index makes the access out of range (no aliasing).
  assign w_oor  = |(wb_adr_i >> (ADDRESS_WIDTH + 2));
  assign w_word = wb_adr_i[ADDRESS_WIDTH+1:2];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= StIdle;
      r_cnt   <= 2'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_stall <= 1'b0;
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= 4'd0;
      r_addr  <= '0;
      r_din   <= 32'd0;
      r_data  <= 32'd0;
    end else begin
      // Strobes and the SRAM command are single-cycle unless re-asserted below.
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_csb <= 1'b1;
      r_web <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (w_req) begin
            r_stall <= 1'b1;
            if (w_oor) begin
              r_state <= StError;
              r_err   <= 1'b1;
            end else if (wb_we_i) begin
              r_state <= StWrite;
              r_ack   <= 1'b1;
              r_csb   <= 1'b0;
              r_web   <= 1'b0;
              r_addr  <= w_word;
              r_din   <= wb_data_i;
              r_wmask <= wb_sel_i;
            end else begin
              r_state <= StReadWait;
              r_csb   <= 1'b0;
              r_addr  <= w_word;
              r_cnt   <= 2'(READ_LATENCY);
            end
          end
        end
        StReadWait: begin
          if (!wb_cyc_i) begin
            // Master abandoned the cycle: drop the pending capture and response.
            r_state <= StIdle;
            r_stall <= 1'b0;
          end else if (r_cnt == 2'd0) begin
            r_data  <= sram_dout0;
            r_ack   <= 1'b1;
            r_state <= StRespond;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        StWrite, StRespond, StError: begin
          r_state <= StIdle;
          r_stall <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign wb_ack_o    = r_ack;
  assign wb_error_o  = r_err;
  assign wb_stall_o  = r_stall;
  assign wb_data_o   = r_data;
  assign sram_csb0   = r_csb;
  assign sram_web0   = r_web;
  assign sram_wmask0 = r_wmask;
  assign sram_addr0  = r_addr;
  assign sram_din0   = r_din;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Bench: two responders (read latency 1 and 3) share one bus; SRAM behaviour and a
// word-level scoreboard live here, with directed and randomized transactions.
module tb_wb_sram_responder;
  localparam int unsigned AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_b, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [27:0] adr;

  logic          ack, stall, err, csb, web;
  logic [31:0]   rdat, sdin, sdout;
  logic [3:0]    wmask;
  logic [AW-1:0] saddr;

  logic          b_ack, b_stall, b_err, b_csb, b_web;
  logic [31:0]   b_rdat, b_sdin, b_sdout;
  logic [3:0]    b_wmask;
  logic [AW-1:0] b_saddr;

  wb_sram_responder #(.ADDRESS_WIDTH(AW), .READ_LATENCY(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_data_i(wdat), .wb_adr_i(adr), .wb_ack_o(ack), .wb_stall_o(stall),
    .wb_error_o(err), .wb_data_o(rdat), .sram_csb0(csb), .sram_web0(web),
    .sram_wmask0(wmask), .sram_addr0(saddr), .sram_din0(sdin), .sram_dout0(sdout)
  );

  wb_sram_responder #(.ADDRESS_WIDTH(AW), .READ_LATENCY(3)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst_b), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_data_i(wdat), .wb_adr_i(adr), .wb_ack_o(b_ack), .wb_stall_o(b_stall),
    .wb_error_o(b_err), .wb_data_o(b_rdat), .sram_csb0(b_csb), .sram_web0(b_web),
    .sram_wmask0(b_wmask), .sram_addr0(b_saddr), .sram_din0(b_sdin), .sram_dout0(b_sdout)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // SRAM macro models: latency 1 and latency 3 read pipelines.
  logic [31:0] mem_a [2**AW];
  logic [31:0] mem_b [2**AW];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];
  always @(posedge clk) begin
    if (!csb) begin
      if (!web) mem_a[saddr] <= merge(mem_a[saddr], sdin, wmask);
      else pipe_a <= mem_a[saddr];
    end
    if (!b_csb) begin
      if (!b_web) mem_b[b_saddr] <= merge(mem_b[b_saddr], b_sdin, b_wmask);
      else pipe_b[0] <= mem_b[b_saddr];
    end
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign sdout   = pipe_a;
  assign b_sdout = pipe_b[2];

  // Scoreboard: expected memory contents and last read word seen by the latency-1 DUT.
  logic [31:0] ref_mem [2**AW];
  logic [31:0] last_rd_a;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  int            cmd_a = 0, cmd_b = 0, overlap = 0;
  logic [3:0]    last_mask;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_din;
  logic          last_web;
  always @(negedge clk) begin
    if (!csb) begin
      cmd_a++;
      last_mask = wmask;
      last_addr = saddr;
      last_din  = sdin;
      last_web  = web;
    end
    if (!b_csb) cmd_b++;
    if ((ack && err) || (b_ack && b_err)) overlap++;
  end

  task automatic chk_reset(input bit ub);
    chk(ub ? "b_rst_ack" : "rst_ack", ub ? b_ack : ack, 0);
    chk(ub ? "b_rst_err" : "rst_err", ub ? b_err : err, 0);
    chk(ub ? "b_rst_stall" : "rst_stall", ub ? b_stall : stall, 0);
    chk(ub ? "b_rst_data" : "rst_data", ub ? b_rdat : rdat, 0);
    chk(ub ? "b_rst_csb" : "rst_csb", ub ? b_csb : csb, 1);
    chk(ub ? "b_rst_web" : "rst_web", ub ? b_web : web, 1);
    chk(ub ? "b_rst_wmask" : "rst_wmask", ub ? b_wmask : wmask, 0);
    chk(ub ? "b_rst_addr" : "rst_addr", ub ? b_saddr : saddr, 0);
    chk(ub ? "b_rst_din" : "rst_din", ub ? b_sdin : sdin, 0);
  endtask

  // One transaction on the shared bus, observed on DUT A (ub=0) or DUT B (ub=1).
  task automatic do_req(input bit ub, input logic w, input logic [27:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    logic        oor, stall_ok;
    int          wa, resp, lat, c0, exp_resp, exp_lat, exp_cmd;
    logic [31:0] data, exp_data;
    oor = (a[27:AW+2] != 0);
    wa  = int'(a[AW+1:2]);
    c0  = ub ? cmd_b : cmd_a;
    chk("idle_stall", ub ? b_stall : stall, 0);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    @(posedge clk); #1;
    stb = 1'b0;
    resp = 0; lat = 0; stall_ok = 1'b1; data = 32'd0;
    while (resp == 0 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!(ub ? b_stall : stall)) stall_ok = 1'b0;
      if (ub ? b_ack : ack) resp = 1;
      if (ub ? b_err : err) resp = resp + 2;
      data = ub ? b_rdat : rdat;
    end
    @(posedge clk); #1;
    cyc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_resp = oor ? 2 : 1;
    exp_lat  = (oor || w) ? 1 : (ub ? 5 : 3);
    exp_cmd  = oor ? 0 : 1;
    exp_data = (!oor && !w) ? ref_mem[wa] : last_rd_a;
    chk("resp_kind", resp, exp_resp);
    chk("resp_latency", lat, exp_lat);
    chk("sram_cmd_count", (ub ? cmd_b : cmd_a) - c0, exp_cmd);
    chk("stall_while_busy", stall_ok, 1);
    if (!ub || (!oor && !w)) chk("rdata", data, exp_data);
    if (!ub && !oor) begin
      chk("cmd_addr", last_addr, wa);
      chk("cmd_web", last_web, !w);
      if (w) begin
        chk("cmd_wmask", last_mask, s);
        chk("cmd_din", last_din, d);
      end
    end
    if (!oor && w) ref_mem[wa] = merge(ref_mem[wa], d, s);
    if (!oor && !w) last_rd_a = ref_mem[wa];
  endtask

  initial begin
    logic        seen;
    int          c0;
    logic [27:0] a;
    for (int i = 0; i < 2**AW; i++) begin
      mem_a[i] = 32'd0; mem_b[i] = 32'd0; ref_mem[i] = 32'd0;
    end
    pipe_a = 32'd0;
    for (int i = 0; i < 3; i++) pipe_b[i] = 32'd0;
    last_rd_a = 32'd0;
    rst = 1'b1; rst_b = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'd0; wdat = 32'd0; adr = 28'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    @(posedge clk); #1;
    rst = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    do_req(0, 1'b1, 28'h0000010, 4'hF, 32'hDEADBEEF);
    do_req(0, 1'b0, 28'h0000010, 4'hF, 32'h0);
    do_req(0, 1'b1, 28'h0000010, 4'h1, 32'h000000AA);
    do_req(0, 1'b0, 28'h0000010, 4'h0, 32'h0);
    chk("byte_merge", last_rd_a, 32'hDEADBEAA);
    do_req(0, 1'b1, 28'h0000800, 4'hF, 32'h11111111);
    do_req(0, 1'b0, 28'h0000800, 4'hF, 32'h0);

    // Read accepted, then cyc dropped in T+2.
    c0 = cmd_a;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 28'h0000010;
    @(posedge clk); #1; stb = 1'b0;
    @(posedge clk); #1; cyc = 1'b0;
    seen = 1'b0;
    @(negedge clk); seen = seen | ack | err;
    @(negedge clk); seen = seen | ack | err;
    chk("drop_no_resp", seen, 0);
    chk("drop_idle_t3", stall, 0);
    chk("drop_data_hold", rdat, last_rd_a);
    chk("drop_cmd_kept", cmd_a - c0, 1);
    do_req(0, 1'b1, 28'h0000040, 4'hC, 32'hCAFEF00D);

    // Latency-3 responder.
    do_req(1, 1'b1, 28'h0000020, 4'hF, 32'h12345678);
    do_req(1, 1'b0, 28'h0000020, 4'hF, 32'h0);

    // Reset asserted during T+2 of a read on the latency-3 responder.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 28'h0000020;
    @(posedge clk); #1; stb = 1'b0;
    @(posedge clk); #1; rst_b = 1'b1;
    @(posedge clk); #1; rst_b = 1'b0;
    @(negedge clk);
    chk_reset(1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | b_ack | b_err;
    end
    chk("b_rst_no_ack", seen, 0);
    cyc = 1'b0;
    last_rd_a = ref_mem[8];
    @(negedge clk);
    @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0)
        a = 28'($urandom) | (28'h800 << $urandom_range(0, 16));
      else if ($urandom_range(0, 3) == 0)
        a = 28'($urandom_range(0, 2**AW - 1) * 4 + $urandom_range(0, 3));
      else
        a = 28'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      do_req(0, 1'($urandom), a, 4'($urandom), $urandom);
    end

    chk("ack_err_exclusive", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sram_responder.md
Name: wb_sram_responder

Overview:
- Wishbone slave that terminates a host-side Wishbone master (28-bit byte address, with ack/stall/error/data returns) onto one port of a single-port OpenRAM-style SRAM macro.
- Sits behind the user-space Wishbone master in the Caravel host path and gives the management core a directly addressable scratch memory.
- One transaction outstanding at a time.
- Out-of-range accesses are answered with a bus error instead of being aliased.

Parameters:
- ADDRESS_WIDTH, 9: SRAM word-address bits; memory size is 2^ADDRESS_WIDTH 32-bit words.
- READ_LATENCY, 1: clock edges from the SRAM capturing a read command to sram_dout0 being valid. Legal range is 1..3.

Ports:
- wb_clk_i  input  1  system clock; all logic on the rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- wb_cyc_i  input  1  bus cycle active.
- wb_stb_i  input  1  request strobe.
- wb_we_i  input  1  1 = write, 0 = read.
- wb_sel_i  input  4  byte lane select.
- wb_data_i  input  32  write data.
- wb_adr_i  input  28  byte address.
- wb_ack_o  output  1  normal termination, single-cycle pulse.
- wb_stall_o  output  1  request not accepted this cycle.
- wb_error_o  output  1  error termination, single-cycle pulse.
- wb_data_o  output  32  read data.
- sram_csb0  output  1  SRAM chip select, active low.
- sram_web0  output  1  SRAM write enable, active low.
- sram_wmask0  output  4  SRAM byte write mask.
- sram_addr0  output  ADDRESS_WIDTH  SRAM word address.
- sram_din0  output  32  SRAM write data.
- sram_dout0  input  32  SRAM read data.

Behaviour:
- Clock and reset: one clock (wb_clk_i). Reset wb_rst_i is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - wb_ack_o = 0, wb_error_o = 0, wb_stall_o = 0, wb_data_o = 0.
  - sram_csb0 = 1, sram_web0 = 1, sram_wmask0 = 0, sram_addr0 = 0, sram_din0 = 0.
  - Latency counter = 0.
  - Reset mid-transaction aborts immediately; no ack or error is issued.
- Output timing: all outputs are registered. wb_stall_o = 1 in every state except IDLE.
- Address decode:
  - Word address = wb_adr_i[ADDRESS_WIDTH+1:2]; wb_adr_i[1:0] are ignored.
  - Out of range when wb_adr_i[27:ADDRESS_WIDTH+2] != 0.
- States:
  - IDLE, on wb_cyc_i & wb_stb_i in cycle T (accept):
    - Out of range → ERROR. No SRAM command is issued.
    - Write → WRITE. Register addr/din, wmask = wb_sel_i; csb0 = 0, web0 = 0 during T+1.
    - Read → READ_WAIT. csb0 = 0, web0 = 1 during T+1; counter loaded with READ_LATENCY.
  - WRITE (T+1):
    - SRAM command active; wb_ack_o = 1 in T+1. Return to IDLE.
    - Next acceptance is possible at T+2.
  - READ_WAIT:
    - csb0 returns to 1 after the single command cycle.
    - Counter decrements each cycle. At 0, capture sram_dout0 into wb_data_o on that edge → RESPOND.
  - RESPOND:
    - wb_ack_o = 1 for one cycle with wb_data_o valid. Return to IDLE.
    - For READ_LATENCY = 1: accept T, command T+1, capture at end of T+2, ack in T+3.
  - ERROR:
    - wb_error_o = 1 for one cycle in T+1; wb_ack_o stays 0. Return to IDLE.
- SRAM command rules: exactly one SRAM command cycle per accepted in-range request. csb0 = 1 at all other times.
- Write with wb_sel_i = 0: SRAM command still issued with wmask0 = 0 (no-op), and ack is given.
- Reads always return the full word; wb_sel_i is ignored.
- wb_data_o holds the last read data; it is not changed by writes or errors.
- Requests presented while wb_stall_o = 1 are ignored. The master must hold them until a cycle with wb_stall_o = 0.
- wb_cyc_i dropped mid-transaction:
  - Return to IDLE on the next edge and suppress the pending ack/error.
  - An SRAM command already issued is not retracted. A read capture in progress is discarded.
- wb_ack_o and wb_error_o are never high in the same cycle.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x0000010 with sel = 0xF → csb0 = 0, web0 = 0, addr0 = 4, wmask0 = 0xF in T+1. ack in T+1; error never asserted.
- Read 0x0000010, SRAM model (READ_LATENCY = 1) returns 0xDEADBEEF → ack exactly in T+3 with wb_data_o = 0xDEADBEEF. stall_o high T+1..T+3.
- Byte write of 0x000000AA with sel = 0x1 to 0x0000010, then read back → wmask0 = 0x1; readback 0xDEADBEAA.
- Access to 0x0000800 (ADDRESS_WIDTH = 9) → error_o pulse in T+1, no ack, csb0 stays 1 throughout.
- Read accepted, then cyc dropped in T+2 → no ack/error pulse, state IDLE by T+3, wb_data_o unchanged. A new write accepted at T+3 completes normally.
- Repeat the read test with READ_LATENCY = 3 → ack in T+5. Assert wb_rst_i at T+2 of a read → all outputs at reset values the following cycle, no ack.
